// File: rtl/data_memory_hs.sv
// ============================================================================
// data_memory_hs : RV32 byte-addressed data memory, valid/ready handshake,
//                  configurable depth and response latency.
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_hs #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     mem [DEPTH];

  logic [IW-1:0]   idx;
  logic [1:0]      lane;
  logic            oob;
  logic            size_bad;
  logic            err;
  logic            accept;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     word;
  logic [31:0]     ld;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign idx      = req_addr[IW+1:2];
  assign oob      = |req_addr[AW-1:IW+2];
  assign size_bad = (req_size == 2'b11);
  assign accept   = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misal;
  assign misal = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign err   = size_bad | oob | misal;
  assign lane  = req_addr[1:0];
`else
  assign err = size_bad | oob;
  // Misaligned halves/words are silently aligned down.
  always_comb begin
    lane = req_addr[1:0];
    case (req_size)
      2'b01:   lane = {req_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = req_addr[1:0];
    endcase
  end
`endif

  always_comb begin
    be = 4'b0000;
    case (req_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wd = (req_size == 2'b00) ? {4{req_wdata[7:0]}}  :
              (req_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;

  // The array has no reset: stores committed before rst stay in place.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign word    = mem[idx];
  assign ld_byte = word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = word;
    case (req_size)
      2'b00:   ld = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld = word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= err;
            resp_rdata <= (req_we || err) ? 32'd0 : ld;
            cnt        <= CW'(LATENCY - 1);
            if (LATENCY > 1) begin
              state <= BUSY;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
